bus_master_single: RTL

Single-outstanding bus initiator: turns a simple valid/ready request port into one `Bus_if` transaction at a time and returns the slave's response on a registered response port. It is the master-side counterpart to slave responders and terminators on the omnibus fabric, used by test masters, config loaders and bridge front-ends. An optional watchdog turns a hung slave, such as an unaccepting terminator, into an explicit timeout status instead of a deadlock.

---
 rtl/Bus.sv | 23 ++
 rtl/Bus_master_pkg.sv | 31 +++
 rtl/Bus_if.sv | 22 ++
 rtl/bus_master_watchdog.sv | 42 ++++
 rtl/bus_master_single.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/Bus.sv
// Bus: command/response encodings and widths shared by all omnibus fabric agents.
package Bus;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    // Master command phase encoding.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2
    } Cmd_t;

    // Slave response encoding; NULL means no response this cycle.
    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        FAIL = 2'd2,
        ERR  = 2'd3
    } Resp_t;

endpackage

// File: rtl/Bus_master_pkg.sv
// Bus_master_pkg: FSM state encoding, response status and slave-response mapping
// for bus_master_single.
package Bus_master_pkg;

    // FSM state encoding kept as plain constants for legacy tools.
    typedef logic [1:0] State_t;
    localparam State_t S_IDLE = 2'd0;
    localparam State_t S_CMD  = 2'd1;
    localparam State_t S_RESP = 2'd2;
    localparam State_t S_DONE = 2'd3;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        FAIL    = 2'd1,
        ERR     = 2'd2,
        TIMEOUT = 2'd3
    } Status_t;

    // Map a non-NULL slave response to the status reported to the requester.
    function automatic Status_t resp_to_status(input Bus::Resp_t resp);
        Status_t status;
        case (resp)
            Bus::DVA:  status = OK;
            Bus::FAIL: status = FAIL;
            Bus::ERR:  status = ERR;
            default:   status = OK;
        endcase
        return status;
    endfunction

endpackage

// File: rtl/Bus_if.sv
// Bus_if: omnibus point-to-point link between one master and one slave.
interface Bus_if;

    Bus::Cmd_t               MCmd;
    logic [Bus::ADDR_W-1:0]  MAddr;
    logic [Bus::DATA_W-1:0]  MData;
    logic [Bus::BE_W-1:0]    MByteEn;
    logic                    SCmdAccept;
    logic [Bus::DATA_W-1:0]  SData;
    Bus::Resp_t              SResp;

    modport master (
        output MCmd, MAddr, MData, MByteEn,
        input  SCmdAccept, SData, SResp
    );

    modport slave (
        input  MCmd, MAddr, MData, MByteEn,
        output SCmdAccept, SData, SResp
    );

endinterface

// File: rtl/bus_master_watchdog.sv
// bus_master_watchdog: 16-bit saturating cycle counter that flags a transaction
// which has spent TIMEOUT_CYCLES cycles waiting on the slave.
module bus_master_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear on transaction start, else count wait cycles up to saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 16'd0;
        end else if (enable_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is only meaningful while the master is waiting on the slave.
    assign expire_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_master_single.sv
// bus_master_single: single-outstanding omnibus initiator. Latches one request,
// issues it on the bus one cycle later, waits for the slave response and returns
// it as a one-cycle registered pulse.
// Optional watchdog: define BUS_MASTER_TIMEOUT_EN to abort hung transactions with
// status TIMEOUT after TIMEOUT_CYCLES cycles in CMD+RESP.
module bus_master_single
    import Bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [Bus::ADDR_W-1:0] req_addr,
    input  logic [Bus::DATA_W-1:0] req_wdata,
    input  logic [Bus::BE_W-1:0]   req_byteen,
    output logic                   rsp_valid,
    output logic [Bus::DATA_W-1:0] rsp_rdata,
    output Status_t                rsp_status,
    Bus_if.master                  bus
);

    State_t                 state_q,      state_d;
    logic                   write_q,      write_d;
    Bus::Cmd_t              mcmd_q,       mcmd_d;
    logic [Bus::ADDR_W-1:0] maddr_q,      maddr_d;
    logic [Bus::DATA_W-1:0] mdata_q,      mdata_d;
    logic [Bus::BE_W-1:0]   mbyteen_q,    mbyteen_d;
    logic                   rsp_valid_q,  rsp_valid_d;
    logic [Bus::DATA_W-1:0] rsp_rdata_q,  rsp_rdata_d;
    Status_t                rsp_status_q, rsp_status_d;
    logic                   wd_expire_s;
    logic                   resp_seen_s;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic wd_clear_s;
    logic wd_enable_s;

    assign wd_clear_s  = (state_q == S_IDLE) && req_valid;
    assign wd_enable_s = (state_q == S_CMD) || (state_q == S_RESP);

    bus_master_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear_s),
        .enable_i (wd_enable_s),
        .expire_o (wd_expire_s)
    );
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign wd_expire_s      = 1'b0;
`endif

    assign resp_seen_s = (bus.SResp != Bus::NULL);

    // Next-state, bus command and response capture; completion beats timeout.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        mcmd_d       = mcmd_q;
        maddr_d      = maddr_q;
        mdata_d      = mdata_q;
        mbyteen_d    = mbyteen_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_status_d = OK;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d   = S_CMD;
                    write_d   = req_write;
                    mcmd_d    = req_write ? Bus::WR : Bus::RD;
                    maddr_d   = req_addr;
                    mdata_d   = req_write ? req_wdata : '0;
                    mbyteen_d = req_byteen;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD, S_RESP: begin
                if ((state_q == S_CMD) && !bus.SCmdAccept) begin
                    if (wd_expire_s) begin
                        state_d      = S_DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = TIMEOUT;
                    end else begin
                        state_d = S_CMD;
                    end
                end else if (resp_seen_s) begin
                    state_d      = S_DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = resp_to_status(bus.SResp);
                    rsp_rdata_d  = (!write_q && (bus.SResp == Bus::DVA)) ? bus.SData : '0;
                end else if (wd_expire_s) begin
                    state_d      = S_DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = TIMEOUT;
                end else begin
                    state_d = S_RESP;
                end
                // The command phase ends on accept or abort; keep it otherwise.
                if (state_d != S_CMD) begin
                    mcmd_d    = Bus::IDLE;
                    maddr_d   = '0;
                    mdata_d   = '0;
                    mbyteen_d = '0;
                end else begin
                    mcmd_d = mcmd_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mcmd_d    = Bus::IDLE;
                maddr_d   = '0;
                mdata_d   = '0;
                mbyteen_d = '0;
            end
        endcase
    end

    // State, bus command and response registers; reset drops MCmd immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            mcmd_q       <= Bus::IDLE;
            maddr_q      <= '0;
            mdata_q      <= '0;
            mbyteen_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= OK;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            mcmd_q       <= mcmd_d;
            maddr_q      <= maddr_d;
            mdata_q      <= mdata_d;
            mbyteen_q    <= mbyteen_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_status  = rsp_status_q;
    assign bus.MCmd    = mcmd_q;
    assign bus.MAddr   = maddr_q;
    assign bus.MData   = mdata_q;
    assign bus.MByteEn = mbyteen_q;

endmodule
